// File: rtl/lsu_pkg.sv
// lsu_pkg: opcode, funct3, MMIO offset, writeback and FSM definitions for the MEM-stage LSU
package lsu_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;
  localparam logic [7:0] MMIO_STAT = 8'h00;
  localparam logic [7:0] MMIO_RX   = 8'h04;
  localparam logic [7:0] MMIO_TX   = 8'h08;
  localparam logic [7:0] MMIO_CYC  = 8'h10;
  localparam logic [7:0] MMIO_INS  = 8'h14;
  localparam logic [7:0] MMIO_CLR  = 8'h18;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_DMEM_WAIT, S_TX_WAIT, S_DONE} state_t;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: lane select and sign/zero extension of a load word
module lsu_load_align import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         rdata,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [2:0]              funct3,
  output logic [XLEN-1:0]         data
);
  logic [XLEN-1:0] sh, b, h, w, bu, hu, wu;
  assign sh = rdata >> {off, 3'b000};
  assign b  = XLEN'($signed(sh[7:0]));
  assign h  = XLEN'($signed(sh[15:0]));
  assign w  = XLEN'($signed(sh[31:0]));
  assign bu = XLEN'(sh[7:0]);
  assign hu = XLEN'(sh[15:0]);
  assign wu = XLEN'(sh[31:0]);
  assign data = funct3 == F3_LB  ? b  :
                funct3 == F3_LH  ? h  :
                funct3 == F3_LW  ? w  :
                funct3 == F3_LBU ? bu :
                funct3 == F3_LHU ? hu :
                funct3 == F3_LWU ? wu : sh;
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit with variable-latency dmem handshake,
// UART and counter MMIO, and writeback control
module lsu_mem_stage import lsu_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter int              CNT_W     = 32,
  parameter logic [XLEN-1:0] MMIO_BASE = XLEN'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              retire,
  output logic              dmem_req,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_we,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready,
  input  logic              uart_tx_ready,
  output logic              uart_tx_valid,
  output logic [7:0]        uart_tx_data,
  output logic              stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   ld_data,
  output logic [1:0]        wb_sel,
  output logic              reg_wen,
  output logic              misaligned
);
  localparam int NB = XLEN/8;
  localparam int OW = $clog2(NB);
  state_t state;
  logic [CNT_W-1:0] cyc, ins;
  logic [XLEN-1:0] mmio_rd, dmem_ld, wrep;
  logic [NB-1:0] smask;
  logic [OW-1:0] off;
  logic [7:0] moff;
  logic [6:0] opc;
  logic [2:0] f3;
  logic act, is_ld, is_st, mis, mmio, go, tx_wr, clr, unused;
  assign unused = ^{inst[31:15], inst[11:7]};
  assign opc = inst[6:0];
  assign f3 = inst[14:12];
  assign off = addr[OW-1:0];
  assign moff = addr[7:0];
  // Gating with rst_n makes the handshake outputs drop the moment reset asserts
  assign act = rst_n && inst_valid;
  assign is_ld = act && opc == OP_LOAD;
  assign is_st = act && opc == OP_STORE;
  assign mis = (is_ld || is_st) && (f3[1:0] == 2'd1 && addr[0] || f3[1] && addr[1:0] != 2'd0 ||
               XLEN == 64 && f3[1:0] == F3_LD[1:0] && addr[2]);
  assign mmio = addr[XLEN-1:8] == MMIO_BASE[XLEN-1:8];
  assign go = state == S_IDLE && (is_ld || is_st) && !mis;
  assign tx_wr = is_st && mmio && moff == MMIO_TX;
  assign clr = go && is_st && mmio && moff == MMIO_CLR;
  assign smask = f3[1:0] == 2'd0 ? NB'(1) : f3[1:0] == 2'd1 ? NB'(3) : f3[1:0] == 2'd2 ? NB'(15) : '1;
  assign wrep = f3[1:0] == 2'd0 ? {NB{wdata[7:0]}} : f3[1:0] == 2'd1 ? {NB/2{wdata[15:0]}} :
                f3[1:0] == 2'd2 ? {NB/4{wdata[31:0]}} : wdata;
  assign dmem_req = go && !mmio || state == S_DMEM_WAIT;
  assign dmem_addr = dmem_req ? {addr[XLEN-1:OW], OW'(0)} : '0;
  assign dmem_we = dmem_req && is_st ? NB'(smask << off) : '0;
  assign dmem_wdata = dmem_req ? wrep : '0;
  assign stall = go || state == S_DMEM_WAIT || state == S_TX_WAIT;
  assign wb_valid = state == S_IDLE && act && (!(is_ld || is_st) || mis) || state == S_DONE;
  assign misaligned = state == S_IDLE && mis;
  assign wb_sel = !act ? WB_ALU : (opc == OP_JAL || opc == OP_JALR) ? WB_PC4 : opc == OP_LOAD ? WB_LOAD : WB_ALU;
  assign reg_wen = act && !is_st && opc != OP_BRANCH && !mis;
  assign uart_rx_ready = go && is_ld && mmio && moff == MMIO_RX && uart_rx_valid;
  assign uart_tx_valid = tx_wr && uart_tx_ready && (go || state == S_TX_WAIT);
  assign uart_tx_data = uart_tx_valid ? wdata[7:0] : 8'h0;
  // MMIO reads bypass lane alignment: registers are returned as whole zero-extended words
  assign mmio_rd = moff == MMIO_STAT ? XLEN'({uart_rx_valid, uart_tx_ready}) :
                   moff == MMIO_RX   ? (uart_rx_valid ? XLEN'(uart_rx_data) : '0) :
                   moff == MMIO_CYC  ? XLEN'(cyc) :
                   moff == MMIO_INS  ? XLEN'(ins) : '0;
  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata (dmem_rdata),
    .off   (off),
    .funct3(f3),
    .data  (dmem_ld)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      ld_data <= '0;
      cyc <= '0;
      ins <= '0;
    end else begin
      cyc <= clr ? '0 : cyc + 1'b1;
      ins <= clr ? '0 : ins + CNT_W'(retire);
      case (state)
        S_IDLE:
          if (go && !mmio) begin
            if (dmem_ack && is_ld) ld_data <= dmem_ld;
            state <= dmem_ack ? S_DONE : S_DMEM_WAIT;
          end else if (go) begin
            if (is_ld) ld_data <= mmio_rd;
            state <= tx_wr && !uart_tx_ready ? S_TX_WAIT : S_DONE;
          end
        S_DMEM_WAIT:
          if (dmem_ack) begin
            if (is_ld) ld_data <= dmem_ld;
            state <= S_DONE;
          end
        S_TX_WAIT: if (uart_tx_ready) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Parametrised memory-stage load/store unit for the RISC-V core: decodes the MEM-stage instruction, drives a variable-latency data-memory handshake, and decodes MMIO (UART, cycle and instret counters).
- Performs byte-lane masking and sign extension on load data.
- Generates wb_sel and reg_wen for writeback, and stalls the pipeline until the access completes.

Parameters:
- XLEN, 32, datapath and address width; must be 32 or 64.
- CNT_W, 32, width of the cycle and instret counters; must be ≤ XLEN.
- MMIO_BASE, 32'h8000_0000, base of the MMIO window; the window is addr[XLEN-1:8] == MMIO_BASE[XLEN-1:8].

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  MEM-stage instruction present.
- inst  in  32  MEM-stage instruction.
- addr  in  XLEN  ALU result (effective address).
- wdata  in  XLEN  store data, unshifted.
- retire  in  1  one instruction retired this cycle.
- dmem_req  out  1  memory request; held until acked.
- dmem_addr  out  XLEN  word-aligned address.
- dmem_we  out  XLEN/8  byte write enables (0 = read).
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_ack  in  1  request complete; rdata valid.
- dmem_rdata  in  XLEN  read data.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  received byte available.
- uart_rx_ready  out  1  pop pulse for the received byte.
- uart_tx_ready  in  1  transmitter can accept a byte.
- uart_tx_valid  out  1  push pulse for the transmit byte.
- uart_tx_data  out  8  transmit byte.
- stall  out  1  freeze the upstream pipeline.
- wb_valid  out  1  one-cycle completion pulse.
- ld_data  out  XLEN  extended load result.
- wb_sel  out  2  0 = ALU, 1 = load, 2 = PC+4.
- reg_wen  out  1  register-file write enable.
- misaligned  out  1  one-cycle misaligned-access pulse.

Behaviour:
- Reset state: FSM in IDLE; every output is 0; both counters are 0.
- Combinational decode:
  - wb_sel = 2 for JAL/JALR, 1 for LOAD, 0 otherwise.
  - reg_wen = inst_valid and not STORE and not BRANCH and not misaligned.
- Alignment rule: halfword requires addr[0]==0; word requires addr[1:0]==0; doubleword (XLEN=64 only) requires addr[2:0]==0.
- Misaligned memory op:
  - No dmem_req and no MMIO side effect.
  - misaligned and wb_valid pulse in the same cycle; no stall.
- Stores:
  - dmem_we = size mask << addr offset.
  - dmem_wdata = wdata replicated across lanes.
- Loads: select the lane by addr offset, then sign- or zero-extend per funct3 (LB/LH/LW/LBU/LHU, plus LD/LWU when XLEN=64).
- FSM states: IDLE, DMEM_WAIT, TX_WAIT, DONE.
- IDLE:
  - Non-memory instruction: no stall; wb_valid=1 combinationally.
  - Memory op to RAM: dmem_req=1 and stall=1, then go to DMEM_WAIT.
  - Memory op to MMIO: go to DONE with stall=1, except a tx write while uart_tx_ready=0, which goes to TX_WAIT.
- DMEM_WAIT:
  - Hold dmem_req, dmem_addr, dmem_we and dmem_wdata stable until dmem_ack.
  - An ack in the same cycle as the request is legal and takes 1 cycle.
  - On ack, register ld_data and go to DONE.
- TX_WAIT: hold stall until uart_tx_ready, then pulse uart_tx_valid and go to DONE.
- DONE: stall=0 and wb_valid=1 for one cycle; ld_data is stable; return to IDLE.
- MMIO map (offset from MMIO_BASE):
  - 0x00 read: {30'b0, rx_valid, tx_ready}.
  - 0x04 read: rx byte zero-extended; uart_rx_ready pulses only if uart_rx_valid; a read with no byte available returns 0.
  - 0x08 write: wdata[7:0] goes to tx.
  - 0x10 read: cycle counter.
  - 0x14 read: instret counter.
  - 0x18 any write: clears both counters on the next edge.
  - Unmapped read returns 0; unmapped write is a no-op.
- Counters:
  - cycle increments every cycle; instret increments on retire.
  - Both wrap at 2^CNT_W and are zero-extended on read.
  - A clear coinciding with an increment: clear wins.
- Reset asserted mid-access: FSM returns to IDLE, dmem_req drops immediately (asynchronous), and the pending access is abandoned.
- inst and addr must be stable while stall=1; the block does not latch them.

Decomposition:
- Package lsu_pkg holds:
  - opcode and funct3 constants;
  - MMIO offsets;
  - the FSM state enum;
  - the wb_sel encodings.
- Sub-module lsu_load_align: purely combinational lane select plus extension, shared with future cache refill paths.

Test Plan:
- LB from addr 0x103, dmem_rdata=0x80AA_BBCC, ack after 3 cycles → stall for 3 cycles, then wb_valid with ld_data=0xFFFF_FF80; LBU from the same address gives 0x0000_0080.
- SH to 0x202 with wdata=0x1234 → dmem_we=4'b1100 and dmem_wdata=0x1234_1234; reg_wen=0.
- LW from 0x101 → misaligned pulse, no dmem_req, reg_wen=0, stall=0.
- Write 0x41 to MMIO 0x08 while tx_ready=0 for 5 cycles → stall held; a single uart_tx_valid pulse with data 0x41 the cycle tx_ready rises.
- Run 100 cycles with 40 retires, then read 0x10 and 0x14 → 100±offset and 40; write 0x18 concurrent with retire → both counters read 0 on the next cycle.
- Assert rst_n=0 during DMEM_WAIT → dmem_req drops asynchronously; after release the state is IDLE and a JAL gives wb_sel=2 and reg_wen=1.
